id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register and operand-prep stage between instruction decode and the ALU.
- Latches the decoded instruction each cycle and re-derives ALUSrc from the opcode: ori/lw/sw/lui select an immediate, everything else selects rt.
- Presents ready-to-use ALU operands (A, B), store data and control to the execute stage.
- Supports a stall (hold) and a flush (bubble insert) from the hazard unit.

Parameters:
- DW, 32, datapath width.
- NOP_WR_ADDR, 5'd0, write address driven for bubbles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_op  in  6  opcode (instr[31:26]).
- id_funct  in  6  funct (instr[5:0]).
- id_rs_data  in  DW  GRF read data for rs.
- id_rt_data  in  DW  GRF read data for rt.
- id_imm16  in  16  instr[15:0].
- id_rt_addr  in  5  instr[20:16].
- id_rd_addr  in  5  instr[15:11].
- stall  in  1  hold current contents.
- flush  in  1  replace contents with bubble.
- ex_valid  out  1  execute stage holds a real instruction.
- ex_alu_a  out  DW  ALU operand A.
- ex_alu_b  out  DW  ALU operand B after ALUSrc mux/extension.
- ex_store_data  out  DW  rt data for sw.
- ex_alu_op  out  3  0=ADD, 1=SUB, 2=OR, 3=PASSB, 4=EQ, 7=NONE.
- ex_reg_write  out  1  GRF write enable.
- ex_wr_addr  out  5  GRF destination.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, except ex_alu_op=7 and ex_wr_addr=NOP_WR_ADDR. Release is synchronous to clk.
- Latency: one cycle. Inputs sampled on the rising edge appear on ex_* in the same cycle after that edge.
- Priority per edge: reset > flush > stall > load.
- flush=1: load bubble (ex_valid=0, all enables 0, alu_op=7, operands 0, wr_addr=NOP_WR_ADDR). Flush wins over a simultaneous stall.
- stall=1 (no flush): every ex_* register holds its value.
- id_valid=0 on load: treated as a bubble, same as flush.
- Decode on load:
  - R-type op=000000: funct 100001 addu → ADD, reg_write, wr_addr=rd. Funct 100011 subu → SUB, reg_write, wr_addr=rd. Funct 000000 (sll $0, nop) and any other funct → bubble.
  - ori 001101 → OR, B=zero-ext imm16, wr_addr=rt, reg_write.
  - lw 100011 → ADD, B=sign-ext imm16, mem_read, reg_write, wr_addr=rt.
  - sw 101011 → ADD, B=sign-ext imm16, mem_write, no reg_write.
  - lui 001111 → PASSB, B={imm16,16'h0}, reg_write, wr_addr=rt.
  - beq 000100 → EQ, B=rt_data, no writes.
  - Any other opcode → bubble.
- ALUSrc is true exactly for op ∈ {001101, 100011, 101011, 001111}. Otherwise B=rt_data.
- ex_alu_a = rs_data for every non-bubble. ex_store_data = rt_data for every non-bubble.
- Destination rule: reg_write with wr_addr==0 forces reg_write=0 (the $0 write is suppressed).
- Reset asserted mid-stall: outputs clear immediately. After release, the stage resumes loading on the first edge with stall=0.

Decomposition:
- Shared package mips_defs: opcode/funct constants (OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_LUI, OP_BEQ, FN_ADDU, FN_SUBU) and ALU op encodings.
- One sub-module is natural: id_ex_decode, purely combinational. It covers opcode → control, ALUSrc and immediate extension.
- The register bank stays in id_ex_stage.

Test Plan:
- ori: ori $5,$3,0x8001 with rs_data=0x0000_00F0 → next cycle alu_a=0x0000_00F0, alu_b=0x0000_8001, alu_op=2, reg_write=1, wr_addr=5.
- lw/sw extension: lw imm=0xFFFC → alu_b=0xFFFF_FFFC, mem_read=1. sw imm=0x0004 with rt_data=0xDEAD_BEEF → alu_b=4, store_data=0xDEAD_BEEF, mem_write=1, reg_write=0.
- lui and addu: lui imm=0x1234 → alu_b=0x1234_0000, alu_op=3. addu with rd=0 → reg_write=0.
- Stall then flush: load subu, hold stall=1 for 3 cycles while inputs change → outputs unchanged. Then stall=1 and flush=1 together → ex_valid=0, alu_op=7.
- Async reset: assert reset low mid-cycle while holding a valid lw → outputs clear before the next edge. After release, the first edge loads a new instruction.
- Unknown op 000010 or id_valid=0 → bubble: all enables 0, ex_valid=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Opcode/funct constants, ALU op encodings and the execute-stage control bundle.
// Shared by the decode logic and the ID/EX pipeline register.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_OR    = 3'd2,
    ALU_PASSB = 3'd3,
    ALU_EQ    = 3'd4,
    ALU_NONE  = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic       valid;
    alu_op_t    alu_op;
    logic       reg_write;
    logic [4:0] wr_addr;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  function automatic ctrl_t bubble_ctrl(input logic [4:0] nop_addr);
    ctrl_t c;
    c.valid     = 1'b0;
    c.alu_op    = ALU_NONE;
    c.reg_write = 1'b0;
    c.wr_addr   = nop_addr;
    c.mem_read  = 1'b0;
    c.mem_write = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_decode.sv
// Opcode/funct to execute control, ALUSrc mux and immediate extension.
// Purely combinational; unsupported encodings and id_valid=0 decode to a bubble.
module id_ex_decode
  import mips_defs::*;
#(
  parameter int         DW          = 32,
  parameter logic [4:0] NOP_WR_ADDR = 5'd0
) (
  input  logic          id_valid,
  input  logic [5:0]    id_op,
  input  logic [5:0]    id_funct,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm16,
  input  logic [4:0]    id_rt_addr,
  input  logic [4:0]    id_rd_addr,
  output ctrl_t         dec_ctrl,
  output logic [DW-1:0] dec_alu_a,
  output logic [DW-1:0] dec_alu_b,
  output logic [DW-1:0] dec_store_data
);

  logic          known;
  logic          alu_src;
  logic [DW-1:0] imm_ext;

  assign alu_src = (id_op == OP_ORI) || (id_op == OP_LW) ||
                   (id_op == OP_SW)  || (id_op == OP_LUI);

  always_comb begin
    imm_ext = '0;
    if (id_op == OP_ORI) begin
      imm_ext[15:0] = id_imm16;
    end else if (id_op == OP_LUI) begin
      imm_ext[31:16] = id_imm16;
    end else begin
      imm_ext = {{(DW-16){id_imm16[15]}}, id_imm16};
    end
  end

  always_comb begin
    dec_ctrl       = bubble_ctrl(NOP_WR_ADDR);
    dec_alu_a      = '0;
    dec_alu_b      = '0;
    dec_store_data = '0;
    known          = 1'b1;
    case (id_op)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wr_addr   = id_rd_addr;
        if (id_funct == FN_ADDU)      dec_ctrl.alu_op = ALU_ADD;
        else if (id_funct == FN_SUBU) dec_ctrl.alu_op = ALU_SUB;
        else                          known = 1'b0;
      end
      OP_ORI: begin
        dec_ctrl.alu_op    = ALU_OR;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wr_addr   = id_rt_addr;
      end
      OP_LW: begin
        dec_ctrl.alu_op    = ALU_ADD;
        dec_ctrl.mem_read  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wr_addr   = id_rt_addr;
      end
      OP_SW: begin
        dec_ctrl.alu_op    = ALU_ADD;
        dec_ctrl.mem_write = 1'b1;
      end
      OP_LUI: begin
        dec_ctrl.alu_op    = ALU_PASSB;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wr_addr   = id_rt_addr;
      end
      OP_BEQ:  dec_ctrl.alu_op = ALU_EQ;
      default: known = 1'b0;
    endcase

    if (id_valid && known) begin
      dec_ctrl.valid = 1'b1;
      // $0 is hardwired; a write to it must never reach the register file
      if (dec_ctrl.wr_addr == 5'd0) dec_ctrl.reg_write = 1'b0;
      dec_alu_a      = id_rs_data;
      dec_alu_b      = alu_src ? imm_ext : id_rt_data;
      dec_store_data = id_rt_data;
    end else begin
      dec_ctrl = bubble_ctrl(NOP_WR_ADDR);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand prep; one cycle from id_* to ex_*.
// Hazard unit controls flow: flush inserts a bubble (beats stall), stall holds all state.
module id_ex_stage
  import mips_defs::*;
#(
  parameter int         DW          = 32,
  parameter logic [4:0] NOP_WR_ADDR = 5'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [5:0]    id_op,
  input  logic [5:0]    id_funct,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm16,
  input  logic [4:0]    id_rt_addr,
  input  logic [4:0]    id_rd_addr,
  input  logic          stall,
  input  logic          flush,
  output logic          ex_valid,
  output logic [DW-1:0] ex_alu_a,
  output logic [DW-1:0] ex_alu_b,
  output logic [DW-1:0] ex_store_data,
  output logic [2:0]    ex_alu_op,
  output logic          ex_reg_write,
  output logic [4:0]    ex_wr_addr,
  output logic          ex_mem_read,
  output logic          ex_mem_write
);

  ctrl_t         dec_ctrl, ex_ctrl;
  logic [DW-1:0] dec_alu_a, dec_alu_b, dec_store_data;
  logic [DW-1:0] alu_a_q, alu_b_q, store_data_q;

  id_ex_decode #(.DW(DW), .NOP_WR_ADDR(NOP_WR_ADDR)) u_decode (
    .id_valid       (id_valid),
    .id_op          (id_op),
    .id_funct       (id_funct),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm16       (id_imm16),
    .id_rt_addr     (id_rt_addr),
    .id_rd_addr     (id_rd_addr),
    .dec_ctrl       (dec_ctrl),
    .dec_alu_a      (dec_alu_a),
    .dec_alu_b      (dec_alu_b),
    .dec_store_data (dec_store_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ctrl      <= bubble_ctrl(NOP_WR_ADDR);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      store_data_q <= '0;
    end else if (flush) begin
      ex_ctrl      <= bubble_ctrl(NOP_WR_ADDR);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      store_data_q <= '0;
    end else if (!stall) begin
      ex_ctrl      <= dec_ctrl;
      alu_a_q      <= dec_alu_a;
      alu_b_q      <= dec_alu_b;
      store_data_q <= dec_store_data;
    end
  end

  assign ex_valid      = ex_ctrl.valid;
  assign ex_alu_a      = alu_a_q;
  assign ex_alu_b      = alu_b_q;
  assign ex_store_data = store_data_q;
  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_wr_addr    = ex_ctrl.wr_addr;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry after each clock edge or reset assertion.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [2:0]  op;
    logic        rw;
    logic [4:0]  wa;
    logic        mr;
    logic        mw;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_op = '0;
  logic [5:0]  id_funct = '0;
  logic [31:0] id_rs_data = '0;
  logic [31:0] id_rt_data = '0;
  logic [15:0] id_imm16 = '0;
  logic [4:0]  id_rt_addr = '0;
  logic [4:0]  id_rd_addr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
  logic [2:0]  ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_wr_addr;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  id_ex_stage #(.DW(32), .NOP_WR_ADDR(5'd0)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
    .ex_wr_addr(ex_wr_addr), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sd, input logic [2:0] op, input logic rw,
                              input logic [4:0] wa, input logic mr, input logic mw);
    exp_t e;
    e = '{valid: v, a: a, b: b, sd: sd, op: op, rw: rw, wa: wa, mr: mr, mw: mw};
    return e;
  endfunction

  localparam exp_t BUBBLE = '{valid: 1'b0, a: 32'h0, b: 32'h0, sd: 32'h0, op: 3'd7,
                              rw: 1'b0, wa: 5'd0, mr: 1'b0, mw: 1'b0};

  // Monitor: compares after every edge/reset assertion for which an expectation is pending
  always @(posedge clk or negedge reset) begin
    exp_t e, act;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = '{valid: ex_valid, a: ex_alu_a, b: ex_alu_b, sd: ex_store_data, op: ex_alu_op,
              rw: ex_reg_write, wa: ex_wr_addr, mr: ex_mem_read, mw: ex_mem_write};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got v=%0b a=%h b=%h sd=%h op=%0d rw=%0b wa=%0d mr=%0b mw=%0b, want v=%0b a=%h b=%h sd=%h op=%0d rw=%0b wa=%0d mr=%0b mw=%0b",
                 nm, act.valid, act.a, act.b, act.sd, act.op, act.rw, act.wa, act.mr, act.mw,
                 e.valid, e.a, e.b, e.sd, e.op, e.rw, e.wa, e.mr, e.mw);
      end
    end
  end

  // Drive one instruction at the falling edge and queue what the next rising edge must show
  task automatic issue(input string nm, input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                       input logic [4:0] rta, input logic [4:0] rda, input logic st,
                       input logic fl, input exp_t e);
    @(negedge clk);
    id_valid = v; id_op = op; id_funct = fn; id_rs_data = rs; id_rt_data = rt;
    id_imm16 = imm; id_rt_addr = rta; id_rd_addr = rda; stall = st; flush = fl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    // Reset from time-zero: asserted at a falling edge, checked asynchronously
    @(negedge clk);
    exp_q.push_back(BUBBLE);
    name_q.push_back("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue("ori", 1, 6'b001101, 6'h01, 32'h0000_00F0, 32'h11, 16'h8001, 5'd5, 5'd16, 0, 0,
          mk(1, 32'h0000_00F0, 32'h0000_8001, 32'h11, 3'd2, 1, 5'd5, 0, 0));
    issue("lw_sext", 1, 6'b100011, 6'h3C, 32'h1000, 32'h22, 16'hFFFC, 5'd7, 5'd31, 0, 0,
          mk(1, 32'h1000, 32'hFFFF_FFFC, 32'h22, 3'd0, 1, 5'd7, 1, 0));
    issue("sw", 1, 6'b101011, 6'h04, 32'h2000, 32'hDEAD_BEEF, 16'h0004, 5'd9, 5'd0, 0, 0,
          mk(1, 32'h2000, 32'h4, 32'hDEAD_BEEF, 3'd0, 0, 5'd0, 0, 1));
    issue("lui", 1, 6'b001111, 6'h34, 32'h55, 32'h66, 16'h1234, 5'd3, 5'd2, 0, 0,
          mk(1, 32'h55, 32'h1234_0000, 32'h66, 3'd3, 1, 5'd3, 0, 0));
    issue("addu_rd0", 1, 6'b000000, 6'b100001, 32'h1, 32'h2, 16'h0021, 5'd4, 5'd0, 0, 0,
          mk(1, 32'h1, 32'h2, 32'h2, 3'd0, 0, 5'd0, 0, 0));
    issue("addu_rd8", 1, 6'b000000, 6'b100001, 32'h10, 32'h20, 16'h4021, 5'd4, 5'd8, 0, 0,
          mk(1, 32'h10, 32'h20, 32'h20, 3'd0, 1, 5'd8, 0, 0));
    issue("ori_rt0", 1, 6'b001101, 6'h0F, 32'h7, 32'h8, 16'h000F, 5'd0, 5'd0, 0, 0,
          mk(1, 32'h7, 32'h0000_000F, 32'h8, 3'd2, 0, 5'd0, 0, 0));
    issue("beq", 1, 6'b000100, 6'h03, 32'h5, 32'h5, 16'h0003, 5'd5, 5'd0, 0, 0,
          mk(1, 32'h5, 32'h5, 32'h5, 3'd4, 0, 5'd0, 0, 0));
    issue("subu", 1, 6'b000000, 6'b100011, 32'h100, 32'h30, 16'h6023, 5'd6, 5'd12, 0, 0,
          mk(1, 32'h100, 32'h30, 32'h30, 3'd1, 1, 5'd12, 0, 0));
    for (int i = 0; i < 3; i++) begin
      issue("stall_hold", 1, 6'b001101, 6'h01, 32'hAAAA_0000 + i, 32'h99, 16'h1111, 5'd9, 5'd2,
            1, 0, mk(1, 32'h100, 32'h30, 32'h30, 3'd1, 1, 5'd12, 0, 0));
    end
    issue("stall_flush", 1, 6'b001101, 6'h01, 32'h3, 32'h4, 16'h1111, 5'd9, 5'd2, 1, 1, BUBBLE);
    issue("unknown_op", 1, 6'b000010, 6'h00, 32'h3, 32'h4, 16'h1111, 5'd9, 5'd2, 0, 0, BUBBLE);
    issue("id_invalid", 0, 6'b001101, 6'h01, 32'h3, 32'h4, 16'h1111, 5'd9, 5'd2, 0, 0, BUBBLE);
    issue("rtype_nop", 1, 6'b000000, 6'b000000, 32'h3, 32'h4, 16'h0000, 5'd0, 5'd0, 0, 0, BUBBLE);
    issue("lw_pre_reset", 1, 6'b100011, 6'h10, 32'h40, 32'h50, 16'h0010, 5'd10, 5'd0, 0, 0,
          mk(1, 32'h40, 32'h10, 32'h50, 3'd0, 1, 5'd10, 1, 0));

    // Async reset during a stall, half a cycle before the next edge
    @(negedge clk);
    stall = 1'b1;
    exp_q.push_back(BUBBLE);
    name_q.push_back("async_reset");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    issue("post_reset_load", 1, 6'b001101, 6'h01, 32'h77, 32'h88, 16'h00FF, 5'd11, 5'd0, 0, 0,
          mk(1, 32'h77, 32'h0000_00FF, 32'h88, 3'd2, 1, 5'd11, 0, 0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
